// File: rtl/sd_block_arbiter_pkg.sv
// Shared types for the SD block arbiter: FSM state / debug encoding and block op encoding.
package sd_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_XFER      = 3'd3,
    S_RELEASE   = 3'd4,
    S_ERROR     = 3'd5
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } blk_op_e;

  function automatic logic [1:0] idx_to_oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_block_arbiter_rr_pick2.sv
// Two-way round-robin pick; last-served pointer resets to 1 so requester 0 wins first.
module rr_pick2
  import sd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       pick
);

  logic last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    pick = 1'b0;
    case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Arbitrates two block requesters onto one SD/SPI host: issue, wait busy, byte transfer, release.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BLOCK_BYTES    = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  op,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1,
  input  logic [1:0]  r_byte,
  input  logic [1:0]  w_byte,
  input  logic [7:0]  wdata_0,
  input  logic [7:0]  wdata_1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [7:0]  rdata,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic [7:0]  spi_data_out,
  output logic        spi_r_block,
  output logic        spi_w_block,
  output logic        spi_r_byte,
  output logic        spi_w_byte,
  output logic        spi_rst,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,
  output logic [2:0]  state_dbg
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    BLK_LAST = 10'(BLOCK_BYTES);

  arb_state_e    state;
  logic          win;
  logic          pick;
  logic [9:0]    cnt;
  logic [TW-1:0] tcnt;
  logic          blk_full;
  logic          win_strobe;
  logic          last_upd;
  logic          to_error;

  assign rdata      = spi_data_out;
  assign state_dbg  = state;
  assign blk_full   = (cnt == BLK_LAST);
  assign win_strobe = win ? (r_byte[1] | w_byte[1]) : (r_byte[0] | w_byte[0]);
  assign last_upd   = (state == S_RELEASE) ||
                      ((state == S_ERROR) && !req[win] && !spi_err);

  // Timeout counts from the issue cycle, so ERROR lands TIMEOUT_CYCLES after issue.
  assign to_error = (spi_err && (state inside {S_ISSUE, S_WAIT_BUSY, S_XFER})) ||
                    ((state == S_WAIT_BUSY) && !spi_busy && (tcnt >= T_LAST));

  rr_pick2 u_pick (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     (last_upd),
    .upd_idx (win),
    .pick    (pick)
  );

  always_comb begin
    spi_r_byte  = 1'b0;
    spi_w_byte  = 1'b0;
    spi_data_in = '0;
    if (state == S_XFER) begin
      spi_data_in = win ? wdata_1 : wdata_0;
      if (!blk_full) begin
        spi_r_byte = r_byte[win];
        spi_w_byte = w_byte[win];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      win            <= 1'b0;
      cnt            <= '0;
      tcnt           <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= '0;
      spi_rst        <= 1'b0;
      spi_r_block    <= 1'b0;
      spi_w_block    <= 1'b0;
      spi_block_addr <= '0;
    end else begin
      done        <= '0;
      err         <= '0;
      spi_r_block <= 1'b0;
      spi_w_block <= 1'b0;
      if (to_error) begin
        state   <= S_ERROR;
        err     <= idx_to_oh(win);
        spi_rst <= 1'b1;
        gnt     <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (|req) begin
              win            <= pick;
              spi_block_addr <= pick ? addr_1 : addr_0;
              tcnt           <= '0;
              state          <= S_ISSUE;
              if (blk_op_e'(op[pick]) == OP_WRITE) spi_w_block <= 1'b1;
              else                                 spi_r_block <= 1'b1;
            end
          end
          S_ISSUE: begin
            tcnt  <= tcnt + TW'(1);
            state <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            tcnt <= tcnt + TW'(1);
            if (spi_busy) begin
              state <= S_XFER;
              gnt   <= idx_to_oh(win);
            end
          end
          S_XFER: begin
            if (!blk_full && win_strobe && !spi_busy) cnt <= cnt + 10'd1;
            if (blk_full && !spi_busy) begin
              state <= S_RELEASE;
              gnt   <= '0;
              done  <= idx_to_oh(win);
            end
          end
          S_RELEASE: begin
            cnt   <= '0;
            state <= S_IDLE;
          end
          S_ERROR: begin
            if (!req[win] && !spi_err) begin
              state   <= S_IDLE;
              spi_rst <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Self-checking bench for sd_block_arbiter: directed block sequences, a routing vector table and randomized transactions.
module tb_sd_block_arbiter;

  localparam int TO = 16;
  localparam int BB = 512;

  logic        clk;
  logic        rst;
  logic [1:0]  req, op, r_byte, w_byte;
  logic [31:0] addr_0, addr_1;
  logic [7:0]  wdata_0, wdata_1;
  logic [1:0]  gnt, done, err;
  logic [7:0]  rdata;
  logic        spi_busy, spi_err;
  logic [7:0]  spi_data_out;
  logic        spi_r_block, spi_w_block, spi_r_byte, spi_w_byte, spi_rst;
  logic [31:0] spi_block_addr;
  logic [7:0]  spi_data_in;
  logic [2:0]  state_dbg;

  sd_block_arbiter #(.TIMEOUT_CYCLES(TO), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr_0(addr_0), .addr_1(addr_1),
    .r_byte(r_byte), .w_byte(w_byte), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_data_out(spi_data_out),
    .spi_r_block(spi_r_block), .spi_w_block(spi_w_block),
    .spi_r_byte(spi_r_byte), .spi_w_byte(spi_w_byte), .spi_rst(spi_rst),
    .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] r, w;
    logic [7:0] d0, d1, dout;
    logic       er, ew;
    logic [7:0] edin, erd;
  } vec_t;

  vec_t tbl[8];
  int   nerr = 0;
  int   nchk = 0;
  int   last_m = 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    r_byte = '0; w_byte = '0; spi_busy = 1'b0; spi_err = 1'b0;
  endtask

  // mode: 0 complete, 1 spi_err at byte k, 2 busy timeout, 3 reset at byte k
  task automatic run_txn(input logic [1:0] pat, input logic [1:0] ops,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input int mode, input int k, input int bdly,
                         input bit rnd, input bit use_tbl);
    int w, cnt, outcome, nfwd;
    logic [1:0] woh;
    bit seen, done_exp, err_exp, exp_r, exp_w;
    logic [7:0] exp_d;
    op = ops; addr_0 = a0; addr_1 = a1; req = pat;
    w   = (pat == 2'b11) ? ((last_m == 1) ? 0 : 1) : ((pat == 2'b10) ? 1 : 0);
    woh = (w == 1) ? 2'b10 : 2'b01;
    seen = 0;
    for (int t = 0; t < 4 && !seen; t++) begin
      step();
      if (spi_r_block || spi_w_block) seen = 1;
    end
    chk("issue_seen", 64'(seen), 64'd1);
    chk("issue", {state_dbg, gnt, spi_r_block, spi_w_block, spi_block_addr},
        {3'd1, 2'b00, ~ops[w], ops[w], (w == 1) ? a1 : a0});
    outcome = -1;
    cnt = 0;
    nfwd = 0;
    if (mode == 2) begin
      for (int t = 1; t <= TO; t++) begin
        step();
        if (t < TO) chk("wait_state", {state_dbg, spi_rst}, {3'd2, 1'b0});
      end
      outcome = 1;
    end else begin
      for (int t = 1; t < bdly; t++) begin
        step();
        chk("wait_state", {state_dbg, spi_r_block, spi_w_block, gnt}, {3'd2, 1'b0, 1'b0, 2'b00});
      end
      spi_busy = 1'b1;
      step();
      chk("xfer_entry", {state_dbg, gnt}, {3'd3, woh});
      if (use_tbl) begin
        for (int i = 0; i < 8; i++) begin
          r_byte = tbl[i].r; w_byte = tbl[i].w;
          wdata_0 = tbl[i].d0; wdata_1 = tbl[i].d1; spi_data_out = tbl[i].dout;
          #1;
          chk($sformatf("tbl_route_%0d", i), {spi_r_byte, spi_w_byte, spi_data_in, rdata, gnt},
              {tbl[i].er, tbl[i].ew, tbl[i].edin, tbl[i].erd, woh});
          step();
        end
      end
      for (int t = 0; t < 3000; t++) begin
        if (rnd) begin
          spi_busy = ($urandom_range(0, 3) == 0);
          r_byte = 2'($urandom); w_byte = 2'($urandom);
        end else begin
          spi_busy = 1'b0;
          r_byte = woh;
          w_byte = (t % 2 == 1) ? ~woh : 2'b00;
        end
        wdata_0 = 8'($urandom); wdata_1 = 8'($urandom); spi_data_out = 8'($urandom);
        if (mode == 1 && cnt == k) spi_err = 1'b1;
        if (mode == 3 && cnt == k) begin
          rst = 1'b0;
          #1;
          chk("rst_outputs", {gnt, done, err, spi_r_block, spi_w_block, spi_r_byte, spi_w_byte,
                              spi_rst, spi_block_addr, spi_data_in, state_dbg}, 64'd0);
          req = '0;
          quiet_inputs();
          step();
          chk("rst_hold", {done, err, gnt, state_dbg}, 64'd0);
          rst = 1'b1;
          last_m = 1;
          outcome = 3;
          break;
        end
        #1;
        exp_r = (cnt < BB) ? r_byte[w] : 1'b0;
        exp_w = (cnt < BB) ? w_byte[w] : 1'b0;
        exp_d = (w == 1) ? wdata_1 : wdata_0;
        chk("xfer_route", {gnt, spi_r_byte, spi_w_byte, spi_data_in, rdata, state_dbg},
            {woh, exp_r, exp_w, exp_d, spi_data_out, 3'd3});
        if (spi_r_byte && !spi_busy) nfwd++;
        err_exp  = spi_err;
        done_exp = (cnt == BB) && !spi_busy && !spi_err;
        if (!spi_err && cnt < BB && (r_byte[w] || w_byte[w]) && !spi_busy) cnt++;
        step();
        if (err_exp)  begin outcome = 1; break; end
        if (done_exp) begin outcome = 0; break; end
      end
      if (outcome < 0) chk("xfer_finished", 64'd0, 64'd1);
    end
    if (outcome == 0) begin
      chk("done_pulse", {state_dbg, gnt, done, err}, {3'd4, 2'b00, woh, 2'b00});
      if (!rnd) chk("fwd_count", 64'(nfwd), 64'(BB));
      req[w] = 1'b0;
      quiet_inputs();
      step();
      chk("done_clear", {state_dbg, done, err}, {3'd0, 2'b00, 2'b00});
      last_m = w;
    end else if (outcome == 1) begin
      chk("err_entry", {state_dbg, err, done, gnt, spi_rst}, {3'd5, woh, 2'b00, 2'b00, 1'b1});
      quiet_inputs();
      for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
        step();
        chk("err_hold", {state_dbg, err, done, gnt, spi_rst}, {3'd5, 2'b00, 2'b00, 2'b00, 1'b1});
      end
      req[w] = 1'b0;
      spi_err = 1'b1;
      step();
      chk("err_spi_held", {state_dbg, spi_rst}, {3'd5, 1'b1});
      spi_err = 1'b0;
      step();
      chk("err_exit", {state_dbg, spi_rst, done, err}, {3'd0, 1'b0, 2'b00, 2'b00});
      last_m = w;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b00, 2'b00, 8'hAA, 8'h55, 8'h3C, 1'b0, 1'b0, 8'h55, 8'h3C};
    tbl[1] = '{2'b10, 2'b00, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 8'h22, 8'h33};
    tbl[2] = '{2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{2'b00, 2'b10, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 8'h34, 8'h56};
    tbl[4] = '{2'b00, 2'b01, 8'h9A, 8'hBC, 8'hDE, 1'b0, 1'b0, 8'hBC, 8'hDE};
    tbl[5] = '{2'b11, 2'b11, 8'h01, 8'h80, 8'h7F, 1'b1, 1'b1, 8'h80, 8'h7F};
    tbl[6] = '{2'b01, 2'b01, 8'hC3, 8'h5A, 8'hA5, 1'b0, 1'b0, 8'h5A, 8'hA5};
    tbl[7] = '{2'b10, 2'b01, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF};

    rst = 1'b0; req = '0; op = '0; addr_0 = '0; addr_1 = '0;
    wdata_0 = '0; wdata_1 = '0; spi_data_out = 8'h5A;
    quiet_inputs();
    step();
    step();
    chk("reset_outputs", {gnt, done, err, spi_r_block, spi_w_block, spi_r_byte, spi_w_byte,
                          spi_rst, spi_block_addr, spi_data_in, state_dbg}, 64'd0);
    chk("reset_rdata", 64'(rdata), 64'h5A);
    rst = 1'b1;
    step();
    chk("idle_no_req", 64'(state_dbg), 64'd0);

    // single read, loser w_byte toggling
    run_txn(2'b01, 2'b00, 32'h10, 32'h20, 0, 0, 3, 1'b0, 1'b0);
    req = '0;

    // contention from reset: 0 first, then 1
    rst = 1'b0; #1; rst = 1'b1; last_m = 1;
    step();
    run_txn(2'b11, 2'b10, 32'hA000, 32'hB000, 0, 0, 4, 1'b1, 1'b0);
    run_txn(2'b10, 2'b10, 32'hA000, 32'hB000, 0, 0, 2, 1'b1, 1'b1);
    req = '0;

    run_txn(2'b01, 2'b01, 32'h1234, 32'h0, 2, 0, 2, 1'b0, 1'b0);
    req = '0;
    run_txn(2'b10, 2'b00, 32'h0, 32'h5678, 1, 100, 5, 1'b0, 1'b0);
    req = '0;
    run_txn(2'b01, 2'b01, 32'h99, 32'h0, 1, BB, 2, 1'b0, 1'b0);
    req = '0;
    run_txn(2'b01, 2'b00, 32'h200, 32'h300, 3, 200, 3, 1'b0, 1'b0);
    run_txn(2'b11, 2'b01, 32'h400, 32'h500, 0, 0, 2, 1'b1, 1'b0);
    req = '0;

    for (int i = 0; i < 10; i++) begin
      int m, md;
      m  = $urandom_range(0, 5);
      md = (m <= 2) ? 0 : m - 2;
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
              md, $urandom_range(1, BB - 1), $urandom_range(2, 12), 1'b1, 1'b0);
      req = '0;
    end

    step();
    chk("final_idle", {state_dbg, gnt, spi_rst}, 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
